// File: rtl/rv32_wb_pkg.sv
// Shared definitions for the RV32IM write-back stage: load funct3 codes and
// the write-port arbiter state encoding.
package rv32_wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_NORMAL      = 1'b0,
    WB_MD_PRIORITY = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_formatter.sv
// Load result formatting: selects the addressed byte/halfword out of the raw
// memory word and sign- or zero-extends it to XLEN.
module load_formatter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] result
);
  import rv32_wb_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data[7:0];
    unique case (addr_lo)
      2'd0: byte_sel = data[7:0];
      2'd1: byte_sel = data[15:8];
      2'd2: byte_sel = data[23:16];
      2'd3: byte_sel = data[31:24];
      default: byte_sel = data[7:0];
    endcase
    // addr_lo[0] is don't-care for halfwords; misalignment traps upstream
    half_sel = addr_lo[1] ? data[31:16] : data[15:0];
  end

  always_comb begin
    result = data;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   result = data;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port master: merges the MEM/WB slot and the MUL/DIV
// result handshake, pipeline first, with a starvation override for MUL/DIV.
module wb_write_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             PIPE_VALID,
  input  logic [4:0]       PIPE_RD,
  input  logic [XLEN-1:0]  PIPE_DATA,
  input  logic             PIPE_ISLOAD,
  input  logic [2:0]       PIPE_FUNCT3,
  input  logic [1:0]       PIPE_ADDR_LO,
  output logic             PIPE_STALL,
  input  logic             MD_VALID,
  input  logic [4:0]       MD_RD,
  input  logic [XLEN-1:0]  MD_DATA,
  output logic             MD_READY,
  output logic             RF_WE,
  output logic [4:0]       RF_WADDR,
  output logic [XLEN-1:0]  RF_WDATA,
  output logic [CNT_W-1:0] WB_COUNT
);
  import rv32_wb_pkg::*;

  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT - 1);

  wb_state_e        state_q, state_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             pipe_claims;
  logic             md_ready;
  logic             pipe_stall;
  logic             grant_pipe;
  logic             grant_md;
  logic [XLEN-1:0]  load_data;
  logic [XLEN-1:0]  pipe_wdata;

  logic             rf_we_q;
  logic [4:0]       rf_waddr_q;
  logic [XLEN-1:0]  rf_wdata_q;
  logic [CNT_W-1:0] wb_count_q;

  load_formatter #(.XLEN(XLEN)) u_fmt (
    .data    (PIPE_DATA),
    .funct3  (PIPE_FUNCT3),
    .addr_lo (PIPE_ADDR_LO),
    .result  (load_data)
  );

  assign pipe_wdata = PIPE_ISLOAD ? load_data : PIPE_DATA;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    md_ready    = 1'b0;
    pipe_stall  = 1'b0;
    // an rd=0 slot is consumed silently and leaves the port free for MUL/DIV
    pipe_claims = PIPE_VALID && (PIPE_RD != 5'd0);
    unique case (state_q)
      WB_NORMAL: begin
        md_ready = RESETN && !pipe_claims;
        if (MD_VALID && !md_ready) begin
          if (starve_q == STARVE_TOP) begin
            state_d  = WB_MD_PRIORITY;
            starve_d = '0;
          end else begin
            starve_d = starve_q + 1'b1;
          end
        end else begin
          starve_d = '0;
        end
      end
      WB_MD_PRIORITY: begin
        md_ready   = 1'b1;
        pipe_stall = 1'b1;
        state_d    = WB_NORMAL;
        starve_d   = '0;
      end
      default: begin
        state_d  = WB_NORMAL;
        starve_d = '0;
      end
    endcase
    grant_pipe = (state_q == WB_NORMAL) && pipe_claims;
    grant_md   = !grant_pipe && MD_VALID && md_ready;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= WB_NORMAL;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_count_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rf_we_q  <= 1'b0;
      if (grant_pipe) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= PIPE_RD;
        rf_wdata_q <= pipe_wdata;
        wb_count_q <= wb_count_q + 1'b1;
      end else if (grant_md) begin
        // rd=0 results complete the handshake but never reach x0
        rf_we_q    <= (MD_RD != 5'd0);
        rf_waddr_q <= MD_RD;
        rf_wdata_q <= MD_DATA;
        if (MD_RD != 5'd0) wb_count_q <= wb_count_q + 1'b1;
      end
    end
  end

  assign MD_READY   = md_ready;
  assign PIPE_STALL = pipe_stall;
  assign RF_WE      = rf_we_q;
  assign RF_WADDR   = rf_waddr_q;
  assign RF_WDATA   = rf_wdata_q;
  assign WB_COUNT   = wb_count_q;

endmodule
